// File: rtl/am_nco_modulator_pkg.sv
// Shared types and constants for the AM modulator that sits behind the NCO.
package am_nco_modulator_pkg;

    // Control states of the NCO consumer.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARM,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Modulation depth is an unsigned 8-bit fraction of 256.
    localparam int unsigned DEPTH_W     = 8;
    localparam int unsigned DEPTH_SHIFT = 8;

    // Envelope bias 2^(mw-1): the unmodulated envelope level.
    function automatic int unsigned env_bias(input int unsigned mw);
        return 32'd1 << (mw - 1);
    endfunction

endpackage

// File: rtl/am_env_mult.sv
// Combinational AM datapath: envelope = bias + (depth * audio) >>> 8,
// output = top OW bits of (carrier * envelope).
module am_env_mult
    import am_nco_modulator_pkg::*;
#(
    parameter int unsigned MPR = 10,
    parameter int unsigned MW  = 8,
    parameter int unsigned OW  = 12
) (
    input  logic signed [MW-1:0]      x_i,
    input  logic        [DEPTH_W-1:0] d_i,
    input  logic signed [MPR-1:0]     sin_i,
    output logic signed [OW-1:0]      am_o
);

    localparam int unsigned DXW = MW + DEPTH_W + 1;
    localparam int unsigned EW  = MW + 1;
    localparam int unsigned PW  = MPR + MW + 1;
    localparam logic signed [DXW-1:0] BIAS = DXW'(env_bias(MW));

    logic signed [DXW-1:0] d_ext;
    logic signed [DXW-1:0] x_ext;
    logic signed [DXW-1:0] dx;
    logic signed [DXW-1:0] s;
    logic        [EW-1:0]  env;
    logic signed [PW-1:0]  sin_ext;
    logic signed [PW-1:0]  env_ext;
    logic signed [PW-1:0]  p;

    // Depth is unsigned and the envelope never goes negative, so both are
    // zero-extended before entering the signed multipliers.
    always_comb begin
        d_ext   = {{(DXW-DEPTH_W){1'b0}}, d_i};
        x_ext   = {{(DXW-MW){x_i[MW-1]}}, x_i};
        dx      = d_ext * x_ext;
        s       = dx >>> DEPTH_SHIFT;
        env     = EW'(BIAS + s);
        sin_ext = {{(PW-MPR){sin_i[MPR-1]}}, sin_i};
        env_ext = {{(PW-EW){1'b0}}, env};
        p       = sin_ext * env_ext;
        am_o    = OW'(p >>> (PW - OW));
    end

endmodule

// File: rtl/am_nco_modulator.sv
// NCO controller/consumer: gates NCO clken for backpressure, captures the
// carrier, applies the AM envelope and presents samples with valid/ready.
module am_nco_modulator
    import am_nco_modulator_pkg::*;
#(
    parameter int unsigned MPR   = 10,
    parameter int unsigned APR   = 16,
    parameter int unsigned MW    = 8,
    parameter int unsigned OW    = 12,
    parameter int unsigned RATIO = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic        [APR-1:0]     cfg_phi_inc_i,
    input  logic                      cfg_we_i,
    input  logic        [DEPTH_W-1:0] cfg_depth_i,
    input  logic signed [MW-1:0]      aud_data_i,
    input  logic                      aud_valid_i,
    output logic                      aud_ready_o,
    output logic                      nco_clken_o,
    output logic        [APR-1:0]     nco_phi_inc_o,
    input  logic signed [MPR-1:0]     nco_sin_i,
    input  logic                      nco_valid_i,
    output logic signed [OW-1:0]      am_o,
    output logic                      am_valid_o,
    input  logic                      am_ready_i,
    output logic                      underrun_o,
    output logic                      busy_o
);

    localparam int unsigned   CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    state_e                state_q, state_d;
    logic                  clken;
    logic                  capture;
    logic                  boundary;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [MW-1:0]  x_q, x_d;
    logic [DEPTH_W-1:0]    d_q, d_d;
    logic signed [OW-1:0]  am_q, am_d;
    logic signed [OW-1:0]  am_prod;
    logic                  am_valid_q, am_valid_d;
    logic                  underrun_q, underrun_d;
    logic [APR-1:0]        phi_q, phi_d;

    am_env_mult #(
        .MPR (MPR),
        .MW  (MW),
        .OW  (OW)
    ) u_env_mult (
        .x_i   (x_q),
        .d_i   (d_q),
        .sin_i (nco_sin_i),
        .am_o  (am_prod)
    );

    // Next-state logic and NCO clock-enable / capture qualification.
    always_comb begin
        state_d = state_q;
        clken   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en_i) state_d = ST_WARM;
            end
            ST_WARM: begin
                clken = 1'b1;
                if (!en_i)           state_d = ST_IDLE;
                else if (nco_valid_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                clken   = ~am_valid_q | am_ready_i;
                capture = clken & nco_valid_i;
                if (!en_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!am_valid_q || am_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the sample counter, audio latch, output register and config.
    always_comb begin
        boundary   = capture && (cnt_q == CNT_LAST);
        cnt_d      = cnt_q;
        x_d        = x_q;
        d_d        = d_q;
        underrun_d = underrun_q;
        am_d       = am_q;
        am_valid_d = am_valid_q;
        phi_d      = cfg_we_i ? cfg_phi_inc_i : phi_q;

        if (capture) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end

        // A fresh audio sample takes effect from the capture after the boundary.
        if (boundary) begin
            if (aud_valid_i) begin
                x_d = aud_data_i;
                d_d = cfg_depth_i;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (capture) begin
            am_d       = am_prod;
            am_valid_d = 1'b1;
        end else if (am_ready_i) begin
            am_valid_d = 1'b0;
        end
    end

    // State and datapath registers, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            d_q        <= '0;
            am_q       <= '0;
            am_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            phi_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            d_q        <= d_d;
            am_q       <= am_d;
            am_valid_q <= am_valid_d;
            underrun_q <= underrun_d;
            phi_q      <= phi_d;
        end
    end

    assign nco_clken_o   = clken;
    assign aud_ready_o   = boundary;
    assign nco_phi_inc_o = phi_q;
    assign am_o          = am_q;
    assign am_valid_o    = am_valid_q;
    assign underrun_o    = underrun_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_am_nco_modulator.sv
// Self-checking bench for am_nco_modulator with a behavioural NCO stand-in.
module tb_am_nco_modulator;

    localparam int MPR   = 10;
    localparam int APR   = 16;
    localparam int MW    = 8;
    localparam int OW    = 12;
    localparam int RATIO = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en_i;
    logic        [APR-1:0] cfg_phi_inc_i;
    logic                  cfg_we_i;
    logic        [7:0]     cfg_depth_i;
    logic signed [MW-1:0]  aud_data_i;
    logic                  aud_valid_i;
    logic                  aud_ready_o;
    logic                  nco_clken_o;
    logic        [APR-1:0] nco_phi_inc_o;
    logic signed [MPR-1:0] nco_sin_i;
    logic                  nco_valid_i;
    logic signed [OW-1:0]  am_o;
    logic                  am_valid_o;
    logic                  am_ready_i;
    logic                  underrun_o;
    logic                  busy_o;

    am_nco_modulator #(
        .MPR   (MPR),
        .APR   (APR),
        .MW    (MW),
        .OW    (OW),
        .RATIO (RATIO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en_i          (en_i),
        .cfg_phi_inc_i (cfg_phi_inc_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_depth_i   (cfg_depth_i),
        .aud_data_i    (aud_data_i),
        .aud_valid_i   (aud_valid_i),
        .aud_ready_o   (aud_ready_o),
        .nco_clken_o   (nco_clken_o),
        .nco_phi_inc_o (nco_phi_inc_o),
        .nco_sin_i     (nco_sin_i),
        .nco_valid_i   (nco_valid_i),
        .am_o          (am_o),
        .am_valid_o    (am_valid_o),
        .am_ready_i    (am_ready_i),
        .underrun_o    (underrun_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int depth;
        int x;
        int sin;
        int exp_am;
    } vec_t;

    vec_t tbl[6];

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int x_m, d_m, cap_cnt, k, bnd_count, auto_seen, sin_fixed;
    bit under_m, warm_skip, aud_auto, sin_fixed_en, adv;
    logic signed [OW-1:0] held;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int am_model(input int sin, input int x, input int d);
        int s, env, p;
        s   = (d * x) >>> 8;
        env = 128 + s;
        p   = sin * env;
        return p >>> 7;
    endfunction

    function automatic int sin_of(input int kk);
        return ((kk * 97 + 13) % 1024) - 512;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        x_m       = 0;
        d_m       = 0;
        cap_cnt   = 0;
        under_m   = 1'b0;
        warm_skip = 1'b1;
    endtask

    // Runs at the falling edge: judges what the coming rising edge will do.
    task automatic monitor();
        bit cap, bnd;
        int got;
        check("am_valid", am_valid_o, int'(exp_q.size() != 0));
        check("underrun", underrun_o, int'(under_m));
        if (am_valid_o && !am_ready_i) check("stall_clken", nco_clken_o, 0);
        if (am_valid_o && am_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=%0d expected=none", am_o);
            end else begin
                got = exp_q.pop_front();
                check("sb_am", int'(am_o), got);
            end
        end
        cap = 1'b0;
        if (nco_clken_o) begin
            if (warm_skip) warm_skip = 1'b0;
            else           cap = nco_valid_i;
        end
        bnd = cap && (cap_cnt == RATIO - 1);
        check("aud_ready", aud_ready_o, int'(bnd));
        if (cap) begin
            exp_q.push_back(am_model(int'(nco_sin_i), x_m, d_m));
            if (bnd) begin
                bnd_count++;
                if (aud_valid_i) begin
                    x_m = int'(aud_data_i);
                    d_m = int'(cfg_depth_i);
                end else begin
                    under_m = 1'b1;
                end
            end
            cap_cnt = (cap_cnt + 1) % RATIO;
        end
    endtask

    // One clock: monitor at negedge, then advance the NCO stand-in after posedge.
    task automatic step();
        @(negedge clk);
        adv = nco_clken_o;
        if (!reset) monitor();
        @(posedge clk);
        #1;
        if (adv) k++;
        nco_sin_i = sin_fixed_en ? MPR'(sin_fixed) : MPR'(sin_of(k));
        if (aud_auto && bnd_count != auto_seen) begin
            auto_seen   = bnd_count;
            aud_data_i  = MW'($urandom);
            cfg_depth_i = 8'($urandom);
        end
    endtask

    task automatic wait_boundary(input string name);
        int start;
        start = bnd_count;
        for (int i = 0; i < 100 && bnd_count == start; i++) step();
        if (bnd_count == start) begin
            checks++;
            failures++;
            $display("FAIL %s actual=timeout required=boundary", name);
        end
    endtask

    initial begin
        tbl[0] = '{depth: 128, x:  127, sin:  511, exp_am:   762};
        tbl[1] = '{depth: 255, x: -128, sin:  511, exp_am:     0};
        tbl[2] = '{depth:   0, x:   55, sin: -512, exp_am:  -512};
        tbl[3] = '{depth: 255, x:  127, sin: -512, exp_am: -1016};
        tbl[4] = '{depth: 200, x:  -50, sin:  300, exp_am:   206};
        tbl[5] = '{depth:  64, x:   -1, sin:   -1, exp_am:    -1};

        reset         = 1'b1;
        en_i          = 1'b1;
        nco_valid_i   = 1'b1;
        am_ready_i    = 1'b1;
        cfg_we_i      = 1'b0;
        cfg_phi_inc_i = '0;
        aud_valid_i   = 1'b1;
        aud_data_i    = '0;
        cfg_depth_i   = '0;
        sin_fixed_en  = 1'b1;
        sin_fixed     = 511;
        nco_sin_i     = 10'sd511;
        k             = 0;
        bnd_count     = 0;
        auto_seen     = 0;
        aud_auto      = 1'b0;
        model_reset();

        // Reset held with en and valid high: everything quiet.
        repeat (2) @(posedge clk);
        #1;
        check("rst_am_valid", am_valid_o, 0);
        check("rst_am", int'(am_o), 0);
        check("rst_clken", nco_clken_o, 0);
        check("rst_aud_ready", aud_ready_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_phi", nco_phi_inc_o, 0);
        reset = 1'b0;

        step();
        check("warm_busy", busy_o, 1);
        check("warm_clken", nco_clken_o, 1);
        check("warm_no_out", am_valid_o, 0);
        step();
        check("run_clken", nco_clken_o, 1);
        step();
        check("first_valid", am_valid_o, 1);
        check("first_am", int'(am_o), 511);

        // Envelope arithmetic: each audio sample takes effect after a boundary.
        for (int i = 0; i < 6; i++) begin
            aud_data_i  = MW'(tbl[i].x);
            cfg_depth_i = 8'(tbl[i].depth);
            sin_fixed   = tbl[i].sin;
            nco_sin_i   = MPR'(tbl[i].sin);
            wait_boundary("tbl_boundary");
            step();
            check($sformatf("tbl_am[%0d]", i), int'(am_o), tbl[i].exp_am);
        end

        // Streaming carrier with random downstream backpressure.
        sin_fixed_en = 1'b0;
        aud_auto     = 1'b1;
        for (int i = 0; i < 60; i++) begin
            am_ready_i = ($urandom_range(3) != 0);
            step();
        end
        am_ready_i = 1'b1;
        repeat (3) step();

        // Five-cycle stall: output frozen and NCO held.
        am_ready_i = 1'b0;
        step();
        held = am_o;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_clken_hold", nco_clken_o, 0);
            check("stall_am_hold", int'(am_o), int'(held));
        end
        am_ready_i = 1'b1;
        repeat (20) step();

        // Brief loss of NCO valid while running.
        nco_valid_i = 1'b0;
        repeat (2) step();
        nco_valid_i = 1'b1;
        repeat (5) step();

        // Missing audio at one boundary: sticky underrun, old sample reused.
        check("underrun_clear", underrun_o, 0);
        aud_valid_i = 1'b0;
        wait_boundary("underrun_boundary");
        aud_valid_i = 1'b1;
        step();
        check("underrun_set", underrun_o, 1);
        repeat (40) step();
        check("underrun_sticky", underrun_o, 1);

        // Phase increment update while running, without output gap.
        cfg_phi_inc_i = 16'h0400;
        cfg_we_i      = 1'b1;
        step();
        cfg_we_i = 1'b0;
        check("phi_load", nco_phi_inc_o, 16'h0400);
        check("phi_no_gap", am_valid_o, 1);
        repeat (4) step();

        // Drain with a pending sample; en re-asserted in DRAIN is ignored.
        am_ready_i = 1'b0;
        step();
        en_i = 1'b0;
        step();
        check("drain_busy", busy_o, 1);
        check("drain_clken", nco_clken_o, 0);
        en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("drain_hold_clken", nco_clken_o, 0);
            check("drain_hold_busy", busy_o, 1);
        end
        am_ready_i = 1'b1;
        step();
        check("drain_idle_busy", busy_o, 0);
        check("drain_idle_valid", am_valid_o, 0);
        warm_skip = 1'b1;
        repeat (25) step();

        // Asynchronous reset mid-stream with a sample pending.
        check("pre_rst_valid", am_valid_o, 1);
        check("pre_rst_clken", nco_clken_o, 1);
        reset = 1'b1;
        #1;
        check("arst_am_valid", am_valid_o, 0);
        check("arst_clken", nco_clken_o, 0);
        check("arst_aud_ready", aud_ready_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_underrun", underrun_o, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
